// File: rtl/j_packer.sv
// j_packer: serial-to-SRAM packer.
//
// Reassembles an LSB-first 8-bit serial element stream into bytes and
// writes one image frame of (W+1)*(H+1) elements into a 9-bit activation
// SRAM. Each word is {zero_skip flag, data[7:0]}. A set flag means
// "this byte is followed by one zero", and that zero occupies no SRAM word.
//
// Build option:
//   J_PACKER_ZERO_SKIP_EN  defined     -> zero-skip encoding with a one-byte
//                                         pending register and a FLUSH state.
//                          not defined -> every byte is written as {0,b}.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   serial_in           data bit, sampled when serial_in_en=1 during RECV
//   serial_in_en        bit-valid qualifier
//   pack_start          start pulse, honoured only in IDLE
//   pack_idle           high while idle
//   start_addr          first SRAM word address (latched at start)
//   img_width_size      image width minus 1 (latched at start)
//   img_height_size     image height minus 1 (latched at start)
//   sram_en, sram_we    one-cycle write strobe (always equal)
//   sram_addr           write address, start_addr + pack_len modulo 2^AW
//   sram_data           {zero_skip flag, data[7:0]}
//   pack_len            words written in the current/last frame
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for pack_start; pack_idle goes high one cycle after entry
// RECV  | assembling bytes and issuing writes
// FLUSH | writing the byte left in the pending register after the frame

module j_packer #(
  parameter int SRAM_DEPTH = 1024,
  localparam int AW = $clog2(SRAM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          serial_in,
  input  logic          serial_in_en,
  input  logic          pack_start,
  output logic          pack_idle,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] img_width_size,
  input  logic [AW-1:0] img_height_size,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [8:0]    sram_data,
  output logic [AW-1:0] pack_len
);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [6:0]    byte_q;     // first seven bits of the byte in flight
  logic [AW-1:0] base_q;
  logic [AW-1:0] wlast_q;
  logic [AW-1:0] hlast_q;
  logic [AW-1:0] col_q;
  logic [AW-1:0] row_q;

  logic          byte_done;
  logic [7:0]    byte_new;
  logic          last_byte;
  logic          wr_fire;
  logic [8:0]    wr_word;

`ifdef J_PACKER_ZERO_SKIP_EN
  logic [7:0]    pend_q;
  logic          pend_vld;
  logic          pend_next;
`endif

  // The 8th bit is taken straight from the input so the byte is usable on
  // the very edge that samples it.
  assign byte_done = (state == RECV) && serial_in_en && (bitcnt == 3'd7);
  assign byte_new  = {serial_in, byte_q};
  assign last_byte = (col_q == wlast_q) && (row_q == hlast_q);
  assign sram_we   = sram_en;

`ifdef J_PACKER_ZERO_SKIP_EN
  // A zero that meets a valid pending byte is folded into that byte's flag;
  // any other byte (including a zero after a folded zero) becomes pending.
  assign pend_next = !(pend_vld && (byte_new == 8'd0));
`endif

  always_comb begin
    wr_fire = 1'b0;
    wr_word = 9'd0;
`ifdef J_PACKER_ZERO_SKIP_EN
    if (byte_done && pend_vld) begin
      wr_fire = 1'b1;
      wr_word = {(byte_new == 8'd0), pend_q};
    end else if (state == FLUSH) begin
      wr_fire = 1'b1;
      wr_word = {1'b0, pend_q};
    end
`else
    if (byte_done) begin
      wr_fire = 1'b1;
      wr_word = {1'b0, byte_new};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pack_idle <= 1'b1;
      sram_en   <= 1'b0;
      sram_addr <= '0;
      sram_data <= 9'd0;
      pack_len  <= '0;
      bitcnt    <= 3'd0;
      byte_q    <= 7'd0;
      base_q    <= '0;
      wlast_q   <= '0;
      hlast_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
`ifdef J_PACKER_ZERO_SKIP_EN
      pend_q    <= 8'd0;
      pend_vld  <= 1'b0;
`endif
    end else begin
      sram_en <= wr_fire;
      if (wr_fire) begin
        sram_addr <= base_q + pack_len;
        sram_data <= wr_word;
        pack_len  <= pack_len + 1'b1;
      end

      case (state)
        IDLE: begin
          pack_idle <= 1'b1;
          if (pack_start) begin
            state     <= RECV;
            pack_idle <= 1'b0;
            base_q    <= start_addr;
            wlast_q   <= img_width_size;
            hlast_q   <= img_height_size;
            col_q     <= '0;
            row_q     <= '0;
            bitcnt    <= 3'd0;
            pack_len  <= '0;
`ifdef J_PACKER_ZERO_SKIP_EN
            pend_vld  <= 1'b0;
`endif
          end
        end

        RECV: begin
          if (serial_in_en) begin
            // Shifting in from the top leaves bit k at position k after
            // seven bits.
            byte_q <= {serial_in, byte_q[6:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          if (byte_done) begin
            if (col_q == wlast_q) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
`ifdef J_PACKER_ZERO_SKIP_EN
            if (pend_next) begin
              pend_q   <= byte_new;
              pend_vld <= 1'b1;
            end else begin
              pend_vld <= 1'b0;
            end
            if (last_byte) begin
              state <= pend_next ? FLUSH : IDLE;
            end
`else
            if (last_byte) begin
              state <= IDLE;
            end
`endif
          end
        end

`ifdef J_PACKER_ZERO_SKIP_EN
        FLUSH: begin
          pend_vld <= 1'b0;
          state    <= IDLE;
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_j_packer.sv
`timescale 1ns/1ps
module tb_j_packer;
  localparam int DEPTH = 1024;
  localparam int AW = 10;

`ifdef J_PACKER_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic serial_in = 1'b0;
  logic serial_in_en = 1'b0;
  logic pack_start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] img_width_size = '0;
  logic [AW-1:0] img_height_size = '0;
  logic pack_idle, sram_en, sram_we;
  logic [AW-1:0] sram_addr, pack_len;
  logic [8:0] sram_data;

  always #5 clk = ~clk;

  j_packer #(.SRAM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .serial_in_en(serial_in_en),
    .pack_start(pack_start), .pack_idle(pack_idle), .start_addr(start_addr),
    .img_width_size(img_width_size), .img_height_size(img_height_size),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_data(sram_data), .pack_len(pack_len)
  );

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t exp_q[$];
  logic [8:0] mem [DEPTH];
  logic [7:0] fb[$];

  // frame model state
  int m_start, m_widx, m_last_wr;
  bit m_pv;
  logic [7:0] m_pd;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  task automatic push_write(input logic [8:0] d, input int c);
    exp_q.push_back('{(m_start + m_widx) % DEPTH, int'(d), c});
    m_widx++;
    m_last_wr = c;
  endtask

  // c is the cycle in which a write caused by this byte must be visible.
  task automatic model_byte(input logic [7:0] b, input int c, input bit last);
    if (!SKIP) begin
      push_write({1'b0, b}, c);
    end else begin
      if (m_pv && b == 8'd0) begin
        push_write({1'b1, m_pd}, c);
        m_pv = 1'b0;
      end else begin
        if (m_pv) push_write({1'b0, m_pd}, c);
        m_pd = b;
        m_pv = 1'b1;
      end
      if (last && m_pv) begin
        push_write({1'b0, m_pd}, c + 1);
        m_pv = 1'b0;
      end
    end
  endtask

  // Compare process: every write strobe is matched against the model queue.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n) begin
      if (sram_en) begin
        chk("wr_we", int'(sram_we), 1);
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(sram_addr), e.addr);
          chk("wr_data", int'(sram_data), e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
        mem[sram_addr] = sram_data;
      end else begin
        chk("idle_we", int'(sram_we), 0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          chk("write_missing", int'(sram_en), 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int gap, input bit ps, output int k);
    repeat (gap) begin
      serial_in_en = 1'b0;
      @(posedge clk); #1;
    end
    serial_in_en = 1'b1;
    serial_in = b;
    pack_start = ps;
    k = cyc;
    @(posedge clk); #1;
    pack_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200; t++) begin
      if (pack_idle) break;
      @(posedge clk); #1;
    end
    chk("wait_idle", int'(pack_idle), 1);
  endtask

  task automatic start_frame(input int start, input int w, input int h);
    wait_idle();
    m_start = start; m_widx = 0; m_pv = 1'b0; m_last_wr = -1;
    start_addr = 10'(start);
    img_width_size = 10'(w);
    img_height_size = 10'(h);
    pack_start = 1'b1;
    @(posedge clk); #1;
    pack_start = 1'b0;
    // scramble the config inputs: the DUT must have latched them
    start_addr = 10'($urandom_range(0, DEPTH - 1));
    img_width_size = 10'($urandom_range(0, DEPTH - 1));
    img_height_size = 10'($urandom_range(0, DEPTH - 1));
    chk("busy_after_start", int'(pack_idle), 0);
    chk("len_cleared", int'(pack_len), 0);
  endtask

  task automatic run_frame(input int start, input int w, input int h, input int gapmax,
                           input bit poke, input bit extra, input int exp_len);
    int k, n, idle_c, mism;
    logic [7:0] b;
    logic [8:0] wd;
    logic [9:0] ai;
    logic [7:0] outb[$];
    n = (w + 1) * (h + 1);
    start_frame(start, w, h);
    for (int i = 0; i < n; i++) begin
      b = fb[i];
      for (int j = 0; j < 8; j++) begin
        send_bit(b[3'(j)], int'($urandom_range(0, gapmax)), poke && i == 1 && j == 0, k);
        if (j == 7) model_byte(b, k + 1, i == n - 1);
      end
    end
    idle_c = -1;
    for (int t = 0; t < 40; t++) begin
      serial_in_en = extra;
      serial_in = 1'($urandom_range(0, 1));
      if (pack_idle) begin
        idle_c = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    serial_in_en = 1'b0;
    chk("idle_latency", idle_c, m_last_wr + 1);
    chk("writes_drained", exp_q.size(), 0);
    chk("pack_len_model", int'(pack_len), m_widx);
    if (exp_len >= 0) chk("pack_len_literal", int'(pack_len), exp_len);
    // decode the frame as a reader would: a flagged word expands to byte, 0
    outb.delete();
    for (int i = 0; i < int'(pack_len); i++) begin
      ai = 10'((start + i) % DEPTH);
      wd = mem[ai];
      outb.push_back(wd[7:0]);
      if (wd[8]) outb.push_back(8'd0);
    end
    mism = 0;
    for (int i = 0; i < n; i++)
      if (i >= outb.size() || outb[i] !== fb[i]) mism++;
    chk("readback_len", outb.size(), n);
    chk("readback_bytes", mism, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) mem[i] = 9'd0;

    #1 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_idle", int'(pack_idle), 1);
    chk("rst_en", int'(sram_en), 0);
    chk("rst_we", int'(sram_we), 0);
    chk("rst_addr", int'(sram_addr), 0);
    chk("rst_data", int'(sram_data), 0);
    chk("rst_len", int'(pack_len), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // plain 10x10 frame, bytes 1..100
    fb.delete();
    for (int i = 1; i <= 100; i++) fb.push_back(8'(i));
    run_frame(0, 9, 9, 0, 1'b0, 1'b0, 100);
    chk("plain_m0", int'(mem[0]), 'h001);
    chk("plain_m99", int'(mem[99]), 'h064);

    // 2x2 frame 5,0,0,7 at 16
    fb = '{8'd5, 8'd0, 8'd0, 8'd7};
    run_frame(16, 1, 1, 0, 1'b0, 1'b0, SKIP ? 3 : 4);
    chk("zs_m16", int'(mem[16]), SKIP ? 'h105 : 'h005);
    chk("zs_m17", int'(mem[17]), 'h000);
    chk("zs_m18", int'(mem[18]), SKIP ? 'h007 : 'h000);
    chk("zs_m19", int'(mem[19]), SKIP ? 'h014 : 'h007);

    // trailing zero, 2x1 frame 9,0, extra enabled bits after the frame
    fb = '{8'd9, 8'd0};
    run_frame(0, 1, 0, 0, 1'b0, 1'b1, SKIP ? 1 : 2);
    chk("tz_m0", int'(mem[0]), SKIP ? 'h109 : 'h009);
    chk("tz_m1", int'(mem[1]), SKIP ? 'h002 : 'h000);

    // single-element frame
    fb = '{8'hA5};
    run_frame(500, 0, 0, 0, 1'b0, 1'b1, 1);
    chk("one_m500", int'(mem[500]), 'h0A5);

    // address wrap
    fb = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_frame(1022, 1, 1, 0, 1'b0, 1'b0, 4);
    chk("wrap_m1023", int'(mem[1023]), 'h002);
    chk("wrap_m1", int'(mem[1]), 'h004);

    // 4x4 random frame with ~30% zeros, enable gaps, ignored mid-frame start
    fb.delete();
    for (int i = 0; i < 16; i++)
      fb.push_back(($urandom_range(0, 9) < 3) ? 8'd0 : 8'($urandom_range(1, 255)));
    run_frame(200, 3, 3, 5, 1'b1, 1'b0, -1);

    // reset after 13 enabled bits of a 4x4 frame
    fb.delete();
    for (int i = 0; i < 16; i++) fb.push_back(8'($urandom_range(1, 255)));
    start_frame(300, 3, 3);
    for (int j = 0; j < 13; j++) begin
      b = fb[j / 8];
      send_bit(b[3'(j % 8)], 0, 1'b0, k);
      if (j % 8 == 7) model_byte(b, k + 1, 1'b0);
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_idle", int'(pack_idle), 1);
    chk("mid_rst_en", int'(sram_en), 0);
    chk("mid_rst_addr", int'(sram_addr), 0);
    chk("mid_rst_data", int'(sram_data), 0);
    chk("mid_rst_len", int'(pack_len), 0);
    exp_q.delete();
    serial_in_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_rst_hold_idle", int'(pack_idle), 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    fb = '{8'd0, 8'd0, 8'd3, 8'd0};
    run_frame(40, 1, 1, 0, 1'b0, 1'b0, SKIP ? 2 : 4);
    chk("rs_m40", int'(mem[40]), SKIP ? 'h100 : 'h000);
    chk("rs_m41", int'(mem[41]), SKIP ? 'h103 : 'h000);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
